// File: rtl/tbird_light_seq_if.sv
// ---------------------------------------------------------------------------
// tbird_light_seq_if
//   Switch and lamp bundle between the switch inputs and the Thunderbird
//   tail-light sequencer.
//   master : switch side, drives en/left/right/haz and observes the lamps
//   slave  : sequencer side, drives la/ra/tick/busy
//   en     : run enable (0 freezes the prescaler and the FSM)
//   left   : left-turn request
//   right  : right-turn request
//   haz    : hazard request
//   la     : left lamps, bit0 innermost
//   ra     : right lamps, bit0 innermost
//   tick   : one-clock prescaler tick
//   busy   : sequencer is away from IDLE
// ---------------------------------------------------------------------------
interface tbird_light_seq_if;
    logic       en;
    logic       left;
    logic       right;
    logic       haz;
    logic [2:0] la;
    logic [2:0] ra;
    logic       tick;
    logic       busy;

    modport master (
        output en, left, right, haz,
        input  la, ra, tick, busy
    );

    modport slave (
        input  en, left, right, haz,
        output la, ra, tick, busy
    );
endinterface

// File: rtl/tbird_light_seq.sv
// ---------------------------------------------------------------------------
// tbird_light_seq
//   Thunderbird tail-light sequencer. A free-running DIV_W-bit prescaler
//   produces a one-clock tick every 2^DIV_W clocks. A Moore FSM advances only
//   on ticks and walks the left or right lamps outward (001, 011, 111), or
//   blinks all six lamps for hazard.
//   clk   : system clock, all flops on posedge
//   rst   : asynchronous active-low reset
//   bus   : slave side of tbird_light_seq_if (en/left/right/haz in,
//           la/ra/tick/busy out)
// ---------------------------------------------------------------------------
module tbird_light_seq #(
    parameter int DIV_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    tbird_light_seq_if.slave  bus
);

    // State encoding; all eight codes are used, but the next-state default
    // still sends anything unexpected back to IDLE on the next tick.
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_L1   = 3'd1;
    localparam logic [2:0] S_L2   = 3'd2;
    localparam logic [2:0] S_L3   = 3'd3;
    localparam logic [2:0] S_R1   = 3'd4;
    localparam logic [2:0] S_R2   = 3'd5;
    localparam logic [2:0] S_R3   = 3'd6;
    localparam logic [2:0] S_HAZ  = 3'd7;

    logic [DIV_W-1:0] cnt_r;
    logic             tick_s;
    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic [2:0]       la_s;
    logic [2:0]       ra_s;
    logic             busy_s;

    // Prescaler: counts while enabled, holds otherwise, wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (bus.en) begin
            cnt_r <= cnt_r + DIV_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Tick is gated by en so a frozen counter parked at all-ones never
    // advances the FSM.
    assign tick_s = bus.en & (&cnt_r);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; requests are only looked at on a tick.
    always_comb begin
        state_nxt_s = state_r;
        if (tick_s) begin
            case (state_r)
                S_IDLE: begin
                    if (bus.haz || (bus.left && bus.right)) begin
                        state_nxt_s = S_HAZ;
                    end else if (bus.left) begin
                        state_nxt_s = S_L1;
                    end else if (bus.right) begin
                        state_nxt_s = S_R1;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                // A started turn runs to step 3 even if its request drops;
                // only hazard can cut it short.
                S_L1:    state_nxt_s = bus.haz ? S_HAZ : S_L2;
                S_L2:    state_nxt_s = bus.haz ? S_HAZ : S_L3;
                S_L3:    state_nxt_s = bus.haz ? S_HAZ : S_IDLE;
                S_R1:    state_nxt_s = bus.haz ? S_HAZ : S_R2;
                S_R2:    state_nxt_s = bus.haz ? S_HAZ : S_R3;
                S_R3:    state_nxt_s = bus.haz ? S_HAZ : S_IDLE;
                // Leaving HAZ unconditionally gives the 1-on/1-off blink.
                S_HAZ:   state_nxt_s = S_IDLE;
                default: state_nxt_s = S_IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Moore output decode from the state flops only.
    always_comb begin
        la_s   = 3'b000;
        ra_s   = 3'b000;
        busy_s = (state_r != S_IDLE);
        case (state_r)
            S_IDLE:  begin la_s = 3'b000; ra_s = 3'b000; end
            S_L1:    begin la_s = 3'b001; ra_s = 3'b000; end
            S_L2:    begin la_s = 3'b011; ra_s = 3'b000; end
            S_L3:    begin la_s = 3'b111; ra_s = 3'b000; end
            S_R1:    begin la_s = 3'b000; ra_s = 3'b001; end
            S_R2:    begin la_s = 3'b000; ra_s = 3'b011; end
            S_R3:    begin la_s = 3'b000; ra_s = 3'b111; end
            S_HAZ:   begin la_s = 3'b111; ra_s = 3'b111; end
            default: begin la_s = 3'b000; ra_s = 3'b000; end
        endcase
    end

    assign bus.la   = la_s;
    assign bus.ra   = ra_s;
    assign bus.busy = busy_s;
    assign bus.tick = tick_s;

endmodule

// File: tb/tb_tbird_light_seq.sv
// ---------------------------------------------------------------------------
// tb_tbird_light_seq
//   Self-checking bench for tbird_light_seq with DIV_W=2 (tick every 4 clk).
//   A table of directed vectors, hand-written corner sequences (single-cycle
//   request, hazard preemption, asynchronous reset mid-sequence) and a
//   randomized run against a behavioural model.
// ---------------------------------------------------------------------------
module tb_tbird_light_seq;

    localparam int DIV_W = 2;
    localparam int PERIOD = 1 << DIV_W;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    tbird_light_seq_if bus ();

    tbird_light_seq #(.DIV_W(DIV_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       en;
        logic       l;
        logic       r;
        logic       h;
        logic [2:0] la;
        logic [2:0] ra;
        logic       busy;
        logic       tick;
    } vec_t;

    vec_t tbl [19];

    // Behavioural model: mode 0 none, 1 left turn, 2 right turn, 3 hazard;
    // step is how many lamps of the turn are lit.
    int m_cnt;
    int m_mode;
    int m_step;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [2:0] la, input logic [2:0] ra,
                           input logic busy, input logic tick);
        chk({name, ".la"},   {5'd0, bus.la},   {5'd0, la});
        chk({name, ".ra"},   {5'd0, bus.ra},   {5'd0, ra});
        chk({name, ".busy"}, {7'd0, bus.busy}, {7'd0, busy});
        chk({name, ".tick"}, {7'd0, bus.tick}, {7'd0, tick});
    endtask

    task automatic drive(input logic en, input logic l, input logic r, input logic h);
        bus.en    = en;
        bus.left  = l;
        bus.right = r;
        bus.haz   = h;
    endtask

    // Advance n clocks, ending on a falling edge.
    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_mode = 0;
        m_step = 0;
    endtask

    // One rising edge of the model, using the inputs present at that edge.
    task automatic model_edge(input logic en, input logic l, input logic r, input logic h);
        if (en) begin
            if (m_cnt == PERIOD - 1) begin
                if (m_mode == 0) begin
                    if (h || (l && r)) m_mode = 3;
                    else if (l) begin m_mode = 1; m_step = 1; end
                    else if (r) begin m_mode = 2; m_step = 1; end
                end else if (m_mode == 3) begin
                    m_mode = 0;
                end else if (h) begin
                    m_mode = 3;
                end else if (m_step == 3) begin
                    m_mode = 0;
                end else begin
                    m_step = m_step + 1;
                end
            end
            m_cnt = (m_cnt + 1) % PERIOD;
        end
    endtask

    function automatic logic [2:0] lamps(input int m, input int side, input int step);
        if (m == 3) return 3'b111;
        if (m == side) return 3'((1 << step) - 1);
        return 3'b000;
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);

        //            cyc en    l     r     h     la      ra      busy  tick
        tbl[0]  = '{3,  1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b1};
        tbl[1]  = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 3'b000, 1'b1, 1'b0};
        tbl[2]  = '{3,  1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 3'b000, 1'b1, 1'b1};
        tbl[3]  = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 3'b011, 3'b000, 1'b1, 1'b0};
        tbl[4]  = '{4,  1'b1, 1'b1, 1'b0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0};
        tbl[5]  = '{4,  1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0};
        tbl[6]  = '{4,  1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 3'b000, 1'b1, 1'b0};
        tbl[7]  = '{4,  1'b1, 1'b0, 1'b1, 1'b0, 3'b011, 3'b000, 1'b1, 1'b0};
        tbl[8]  = '{4,  1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0};
        tbl[9]  = '{4,  1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0};
        tbl[10] = '{4,  1'b1, 1'b1, 1'b1, 1'b0, 3'b111, 3'b111, 1'b1, 1'b0};
        tbl[11] = '{4,  1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0};
        tbl[12] = '{4,  1'b1, 1'b0, 1'b0, 1'b1, 3'b111, 3'b111, 1'b1, 1'b0};
        tbl[13] = '{10, 1'b0, 1'b0, 1'b0, 1'b0, 3'b111, 3'b111, 1'b1, 1'b0};
        tbl[14] = '{3,  1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 3'b111, 1'b1, 1'b1};
        tbl[15] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0};
        tbl[16] = '{4,  1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 3'b001, 1'b1, 1'b0};
        tbl[17] = '{4,  1'b1, 1'b0, 1'b0, 1'b1, 3'b111, 3'b111, 1'b1, 1'b0};
        tbl[18] = '{4,  1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0};

        // Reset state while rst is held across edges.
        run(2);
        chk_all("reset", 3'b000, 3'b000, 1'b0, 1'b0);
        rst = 1'b1;

        // Directed table; the counter starts at 0 on release.
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].en, tbl[i].l, tbl[i].r, tbl[i].h);
            run(tbl[i].cyc);
            chk_all($sformatf("tbl%0d", i), tbl[i].la, tbl[i].ra, tbl[i].busy, tbl[i].tick);
        end

        // Right request lasting only the single clock of a tick.
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        run(3);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        run(1);
        chk_all("rpulse1", 3'b000, 3'b001, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        run(4);
        chk_all("rpulse2", 3'b000, 3'b011, 1'b1, 1'b0);
        run(4);
        chk_all("rpulse3", 3'b000, 3'b111, 1'b1, 1'b0);
        run(4);
        chk_all("rpulse4", 3'b000, 3'b000, 1'b0, 1'b0);
        run(4);
        chk_all("rpulse5", 3'b000, 3'b000, 1'b0, 1'b0);

        // Hazard raised while in L2, then held: blink.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        run(8);
        chk_all("preempt_l2", 3'b011, 3'b000, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        run(4);
        chk_all("preempt_on", 3'b111, 3'b111, 1'b1, 1'b0);
        run(4);
        chk_all("blink_off", 3'b000, 3'b000, 1'b0, 1'b0);
        run(4);
        chk_all("blink_on", 3'b111, 3'b111, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        run(4);
        chk_all("blink_end", 3'b000, 3'b000, 1'b0, 1'b0);

        // Asynchronous reset in the middle of L3.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        run(12);
        chk_all("pre_rst_l3", 3'b111, 3'b000, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        run(3);
        #2 rst = 1'b0;
        #1 chk_all("async_rst", 3'b000, 3'b000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        run(2);
        chk_all("post_rst2", 3'b000, 3'b000, 1'b0, 1'b0);
        run(1);
        chk_all("post_rst3", 3'b000, 3'b000, 1'b0, 1'b1);

        // Randomized run against the model.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            logic en_v, l_v, r_v, h_v;
            en_v = ($urandom_range(0, 7) != 0);
            l_v  = ($urandom_range(0, 3) == 0);
            r_v  = ($urandom_range(0, 3) == 0);
            h_v  = ($urandom_range(0, 9) == 0);
            drive(en_v, l_v, r_v, h_v);
            @(posedge clk);
            model_edge(en_v, l_v, r_v, h_v);
            @(negedge clk);
            chk_all("rand", lamps(m_mode, 1, m_step), lamps(m_mode, 2, m_step),
                    (m_mode != 0), en_v && (m_cnt == PERIOD - 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
